// File: rtl/branch_pkg.sv
// Shared opcodes, instruction field positions and FSM state encoding for the
// branch redirect controller.
package branch_pkg;

  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_BEQ = 6'b000100;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int IDX_MSB = 25;
  localparam int IMM_MSB = 15;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_OPS = 2'd1,
    REDIRECT = 2'd2
  } state_e;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational target generation: j uses the 26-bit index inside the pc4 region,
// beq uses pc4 plus the sign-extended word offset (32-bit wrap-around).
module branch_target_calc
  import branch_pkg::*;
(
  input  logic [IDX_MSB:0] ir_idx,
  input  logic [31:0]      pc4,
  output logic [31:0]      jmp_target,
  output logic [31:0]      beq_target
);

  logic [31:0] beq_offset;

  assign beq_offset = {{14{ir_idx[IMM_MSB]}}, ir_idx[IMM_MSB:0], 2'b00};
  assign jmp_target = {pc4[31:28], ir_idx, 2'b00};
  assign beq_target = pc4 + beq_offset;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves j/beq in ID, stalls fetch while beq operands are pending, then emits a
// one-cycle PC redirect with ID flush. Define BRANCH_STATS_EN for the stat_* counters.
module branch_redirect_ctrl
  import branch_pkg::*;
  #(parameter int CNT_W = 16)
(
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_ir,
  input  logic [31:0] id_pc4,
  input  logic        rs_busy,
  input  logic        rt_busy,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        fetch_stall,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        id_flush,
  output logic        ctl_done,
  output logic [1:0]  dbg_state
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_ntaken,
  output logic [CNT_W-1:0] stat_wait
`endif
);

  state_e           state_q;
  logic [IDX_MSB:0] ir_q;
  logic [31:0]      pc4_q;
  logic             pc_load_q, id_flush_q, ctl_done_q;
  logic [31:0]      pc_target_q;

  logic [5:0]       opcode;
  logic             is_j, is_beq, is_ctl, ops_busy, ops_eq;
  logic             go_redirect, go_wait, go_ntaken;
  logic [IDX_MSB:0] calc_idx;
  logic [31:0]      calc_pc4, jmp_target, beq_target, target_d;

  assign opcode   = id_ir[OPC_MSB:OPC_LSB];
  assign is_j     = id_valid & (opcode == OPC_J);
  assign is_beq   = id_valid & (opcode == OPC_BEQ);
  assign is_ctl   = is_j | is_beq;
  assign ops_busy = rs_busy | rt_busy;
  assign ops_eq   = (rs_val == rt_val);

  // Once out of RUN the latched copy is authoritative; ID may change underneath.
  assign calc_idx = (state_q == RUN) ? id_ir[IDX_MSB:0] : ir_q;
  assign calc_pc4 = (state_q == RUN) ? id_pc4 : pc4_q;

  branch_target_calc u_calc (
    .ir_idx     (calc_idx),
    .pc4        (calc_pc4),
    .jmp_target (jmp_target),
    .beq_target (beq_target)
  );

  assign target_d = (state_q == RUN && is_j) ? jmp_target : beq_target;

  always_comb begin
    go_redirect = 1'b0;
    go_wait     = 1'b0;
    go_ntaken   = 1'b0;
    case (state_q)
      RUN: begin
        if (is_j) go_redirect = 1'b1;
        else if (is_beq) begin
          if (ops_busy)    go_wait     = 1'b1;
          else if (ops_eq) go_redirect = 1'b1;
          else             go_ntaken   = 1'b1;
        end
      end
      WAIT_OPS: begin
        if (!ops_busy) begin
          if (ops_eq) go_redirect = 1'b1;
          else        go_ntaken   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      ir_q        <= '0;
      pc4_q       <= '0;
      pc_load_q   <= 1'b0;
      id_flush_q  <= 1'b0;
      ctl_done_q  <= 1'b0;
      pc_target_q <= '0;
    end else begin
      pc_load_q  <= go_redirect;
      id_flush_q <= go_redirect;
      ctl_done_q <= go_redirect | go_ntaken;
      if (go_redirect) pc_target_q <= target_d;
      if (state_q == RUN && is_ctl) begin
        ir_q  <= id_ir[IDX_MSB:0];
        pc4_q <= id_pc4;
      end
      case (state_q)
        RUN: begin
          if (go_redirect)  state_q <= REDIRECT;
          else if (go_wait) state_q <= WAIT_OPS;
        end
        WAIT_OPS: begin
          if (go_redirect)    state_q <= REDIRECT;
          else if (go_ntaken) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // REDIRECT never stalls: the ID instruction is being flushed that cycle.
  assign fetch_stall = (state_q == WAIT_OPS) | ((state_q == RUN) & is_ctl);
  assign pc_load     = pc_load_q;
  assign id_flush    = id_flush_q;
  assign ctl_done    = ctl_done_q;
  assign pc_target   = pc_target_q;
  assign dbg_state   = state_q;

`ifdef BRANCH_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] taken_q, ntaken_q, wait_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      taken_q  <= '0;
      ntaken_q <= '0;
      wait_q   <= '0;
    end else begin
      if (go_redirect && taken_q != CNT_MAX) taken_q  <= taken_q + CNT_W'(1);
      if (go_ntaken && ntaken_q != CNT_MAX)  ntaken_q <= ntaken_q + CNT_W'(1);
      if (state_q == WAIT_OPS && wait_q != CNT_MAX) wait_q <= wait_q + CNT_W'(1);
    end
  end

  assign stat_taken  = taken_q;
  assign stat_ntaken = ntaken_q;
  assign stat_wait   = wait_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: per-cycle vector table plus hand-written
// reset sequences; stat_* checks apply when BRANCH_STATS_EN is defined.
module tb_branch_redirect_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_ir, id_pc4;
  logic        rs_busy, rt_busy;
  logic [31:0] rs_val, rt_val;
  logic        fetch_stall, pc_load, id_flush, ctl_done;
  logic [31:0] pc_target;
  logic [1:0]  dbg_state;
`ifdef BRANCH_STATS_EN
  logic [3:0]  stat_taken, stat_ntaken, stat_wait;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       nm;
    logic        v;
    logic [31:0] ir, pc4;
    logic        rsb, rtb;
    logic [31:0] rs, rt;
    logic        e_stall, e_load, e_done;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[$];

  branch_redirect_ctrl #(.CNT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_ir       (id_ir),
    .id_pc4      (id_pc4),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .fetch_stall (fetch_stall),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .id_flush    (id_flush),
    .ctl_done    (ctl_done),
    .dbg_state   (dbg_state)
`ifdef BRANCH_STATS_EN
    ,
    .stat_taken  (stat_taken),
    .stat_ntaken (stat_ntaken),
    .stat_wait   (stat_wait)
`endif
  );

  // Clock and reset
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc4,
                       input logic rsb, input logic rtb, input logic [31:0] rs,
                       input logic [31:0] rt);
    id_valid = v;
    id_ir    = ir;
    id_pc4   = pc4;
    rs_busy  = rsb;
    rt_busy  = rtb;
    rs_val   = rs;
    rt_val   = rt;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic vec_t mk(input string nm, input logic v, input logic [31:0] ir,
                              input logic [31:0] pc4, input logic rsb, input logic rtb,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic st, input logic ld, input logic dn,
                              input logic [31:0] tgt);
    vec_t r;
    r.nm = nm; r.v = v; r.ir = ir; r.pc4 = pc4; r.rsb = rsb; r.rtb = rtb;
    r.rs = rs; r.rt = rt; r.e_stall = st; r.e_load = ld; r.e_done = dn; r.e_tgt = tgt;
    return r;
  endfunction

  initial begin
    // Each row: inputs for one cycle, outputs expected in that same cycle.
    vecs.push_back(mk("j",          1, 32'h08000010, 32'h00400004, 0, 0, 0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk("j_in_redir", 1, 32'h08000020, 32'h0,        0, 0, 0, 0, 0, 1, 1, 32'h40));
    vecs.push_back(mk("idle",       0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h40));
    vecs.push_back(mk("alu",        1, 32'h00221820, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h40));
    vecs.push_back(mk("beq_tk",     1, 32'h10220003, 32'h100,      0, 0, 5, 5, 1, 0, 0, 32'h40));
    vecs.push_back(mk("beq_tk_out", 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 1, 32'h10C));
    vecs.push_back(mk("beq_nt",     1, 32'h10220003, 32'h100,      0, 0, 5, 6, 1, 0, 0, 32'h10C));
    vecs.push_back(mk("beq_nt_out", 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 1, 32'h10C));
    vecs.push_back(mk("busy0",      1, 32'h1000FFFF, 32'h200,      1, 0, 7, 7, 1, 0, 0, 32'h10C));
    vecs.push_back(mk("busy1",      1, 32'h08000010, 32'h0,        1, 0, 0, 0, 1, 0, 0, 32'h10C));
    vecs.push_back(mk("busy2",      0, 32'h0,        32'h0,        1, 0, 0, 0, 1, 0, 0, 32'h10C));
    vecs.push_back(mk("busy_clr",   0, 32'h0,        32'h0,        0, 0, 9, 9, 1, 0, 0, 32'h10C));
    vecs.push_back(mk("busy_out",   0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 1, 32'h1FC));
    vecs.push_back(mk("wnt0",       1, 32'h10220003, 32'h100,      0, 1, 1, 1, 1, 0, 0, 32'h1FC));
    vecs.push_back(mk("wnt_clr",    0, 32'h0,        32'h0,        0, 0, 1, 2, 1, 0, 0, 32'h1FC));
    vecs.push_back(mk("wnt_out",    0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 1, 32'h1FC));
    vecs.push_back(mk("beq_wrap",   1, 32'h10008000, 32'h00010000, 0, 0, 0, 0, 1, 0, 0, 32'h1FC));
    vecs.push_back(mk("wrap_out",   0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 1, 32'hFFFF0000));
    vecs.push_back(mk("j_hi",       1, 32'h0BFFFFFF, 32'hF0000000, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF0000));
    vecs.push_back(mk("j_hi_out",   0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFC));
    vecs.push_back(mk("beq_novld",  0, 32'h10220003, 32'h100,      0, 0, 3, 3, 0, 0, 0, 32'hFFFFFFFC));
    vecs.push_back(mk("novld_out",  0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFC));

    reset = 1'b1;
    idle();
    repeat (2) @(negedge clock);
    chk("rst_state",  32'(dbg_state), 32'd0);
    chk("rst_load",   32'(pc_load),   32'd0);
    chk("rst_flush",  32'(id_flush),  32'd0);
    chk("rst_done",   32'(ctl_done),  32'd0);
    chk("rst_target", pc_target,      32'h0);
    chk("rst_stall",  32'(fetch_stall), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].v, vecs[i].ir, vecs[i].pc4, vecs[i].rsb, vecs[i].rtb, vecs[i].rs, vecs[i].rt);
      #1;
      if (vecs[i].e_load) exp_q.push_back(vecs[i].e_tgt);
      chk({vecs[i].nm, "_stall"}, 32'(fetch_stall), 32'(vecs[i].e_stall));
      chk({vecs[i].nm, "_load"},  32'(pc_load),     32'(vecs[i].e_load));
      chk({vecs[i].nm, "_flush"}, 32'(id_flush),    32'(vecs[i].e_load));
      chk({vecs[i].nm, "_done"},  32'(ctl_done),    32'(vecs[i].e_done));
      chk({vecs[i].nm, "_tgt"},   pc_target,        vecs[i].e_tgt);
      // Scoreboard: every observed redirect must match an expected target.
      if (pc_load) begin
        if (exp_q.size() == 0) chk({vecs[i].nm, "_unexp_load"}, 32'd1, 32'd0);
        else chk({vecs[i].nm, "_sb_tgt"}, pc_target, exp_q.pop_front());
      end
`ifdef BRANCH_STATS_EN
      if (vecs[i].nm == "busy_out") chk("stat_wait_busy", 32'(stat_wait), 32'd3);
`endif
    end
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

`ifdef BRANCH_STATS_EN
    chk("stat_taken",  32'(stat_taken),  32'd5);
    chk("stat_ntaken", 32'(stat_ntaken), 32'd2);
    chk("stat_wait",   32'(stat_wait),   32'd4);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      drive(1'b1, 32'h08000010, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
      idle();
    end
    @(negedge clock);
    #1;
    chk("stat_taken_sat", 32'(stat_taken), 32'd15);
`endif

    // Reset in the middle of WAIT_OPS.
    @(negedge clock);
    drive(1'b1, 32'h10220003, 32'h100, 1'b1, 1'b0, 32'h4, 32'h4);
    @(negedge clock);
    #1;
    chk("wait_entered", 32'(dbg_state), 32'd1);
    id_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rstw_state", 32'(dbg_state),   32'd0);
    chk("rstw_stall", 32'(fetch_stall), 32'd0);
    chk("rstw_load",  32'(pc_load),     32'd0);
    chk("rstw_tgt",   pc_target,        32'h0);
`ifdef BRANCH_STATS_EN
    chk("rstw_stat",  32'(stat_taken),  32'd0);
`endif
    @(negedge clock);
    reset = 1'b0;
    rs_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1;
      chk("rstw_after_load",  32'(pc_load),     32'd0);
      chk("rstw_after_stall", 32'(fetch_stall), 32'd0);
    end

    // Reset in the middle of REDIRECT.
    @(negedge clock);
    drive(1'b1, 32'h08000010, 32'h00400004, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clock);
    idle();
    #1;
    chk("redir_entered", 32'(pc_load), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstr_load",  32'(pc_load),   32'd0);
    chk("rstr_flush", 32'(id_flush),  32'd0);
    chk("rstr_done",  32'(ctl_done),  32'd0);
    chk("rstr_state", 32'(dbg_state), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      chk("rstr_after_load", 32'(pc_load), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
